blit_cmd_fetch: RTL and testbench
=================================

# blit_cmd_fetch

Blitter command/parameter fetch responder. Services the outer-loop controller's read-command and read-parameter requests by issuing byte reads over the blitter's memory-read handshake. It latches the command byte and streams four parameter bytes to the parameter registers. It returns the completion pulses COMDN/PARDN and the command-derived flags PARRD/SRCUP/DSTUP that the outer loop consumes.

## Interface
Parameters: none; byte count and field positions are fixed below.

- CCLK  input  1  system clock; all state changes on rising edge
- SRESET  input  1  synchronous reset, active-high
- RDCMD  input  1  request: fetch command byte (one-cycle pulse from outer loop)
- RDPAR  input  1  request: fetch parameter block (one-cycle pulse from outer loop)
- RDACK  input  1  memory read acknowledge; RDDATA valid in the same cycle
- RDDATA  input  8  read data
- RDREQ  output  1  memory read request, level
- CPINC  output  1  one-cycle pulse: advance command pointer (external address counter)
- CMDREG  output  8  latched command byte
- PARRD  output  1  CMDREG[7]: reload parameters between outer passes
- DSTUP  output  1  CMDREG[6]: destination address update enabled
- SRCUP  output  1  CMDREG[5]: source address update enabled
- PARWR  output  1  one-cycle strobe: write PARDAT to parameter register PARIDX
- PARIDX  output  2  parameter index: 0 outer count, 1 inner count, 2 step, 3 pattern
- PARDAT  output  8  parameter data, registered
- COMDN  output  1  one-cycle pulse: command fetch complete
- PARDN  output  1  one-cycle pulse: parameter fetch complete
- BUSY  output  1  high in any state other than IDLE

## Operation
- States: IDLE, CMD, PAR0, PAR1, PAR2, PAR3.
- IDLE: RDCMD=1 → CMD. RDPAR=1 (RDCMD=0) → PAR0. RDCMD and RDPAR together → CMD. RDPAR is dropped; the outer loop reissues it.
- RDCMD/RDPAR outside IDLE are ignored; no queueing.
- RDREQ = 1 in CMD and PAR0–PAR3. It is decoded from registered state with no combinational path from RDACK.
- In CMD, RDACK=1: CMDREG ← RDDATA, CPINC pulse, next state IDLE, COMDN pulse.
- In PARk, RDACK=1: PARDAT ← RDDATA, PARIDX ← k, PARWR pulse, CPINC pulse.
  - k<3 → PAR(k+1).
  - k=3 → IDLE, PARDN pulse.
- RDACK with RDREQ=0 (in IDLE) is ignored entirely: no capture, no CPINC.
- PARRD/SRCUP/DSTUP are continuous decodes of CMDREG. CMDREG changes only on a CMD acknowledge or on reset.
- PARIDX wraps naturally at 3; it is never incremented past a PAR3 acknowledge.
- Reset, including mid-fetch:
  - State → IDLE.
  - CMDREG, PARDAT and PARIDX → 0.
  - All strobes, pulses, RDREQ and BUSY → 0.
  - A partially fetched parameter block is abandoned and no PARDN is issued.
  - Reset takes priority over RDACK in the same cycle.

## Timing
- Reset value of every output is 0.
- Request pulse in cycle N → state/RDREQ/BUSY high in N+1.
- Acknowledge in cycle M:
  - CMDREG/PARDAT/PARIDX updated, and CPINC/PARWR/COMDN/PARDN high, in cycle M+1, all for exactly one cycle.
  - RDREQ is still high during M. In M+1 it is high for the next byte, or 0 if returning to IDLE.
- Zero-wait memory (RDACK the first cycle RDREQ is high):
  - Command fetch: 2 cycles from request to COMDN.
  - Parameter fetch: 5 cycles from request to PARDN.
- Back-to-back: a request in the same cycle as COMDN/PARDN is accepted, because state is IDLE in that cycle. Earliest next RDREQ is one cycle after the done pulse.
- PARWR and PARDAT/PARIDX are valid in the same cycle; consumers sample on that edge.

## Test plan
- Reset then idle 10 cycles → all outputs 0, RDREQ never asserted.
- RDCMD pulse, RDACK after 3 wait cycles with RDDATA=0xE0 → one CPINC, COMDN one cycle; CMDREG=0xE0, PARRD=DSTUP=SRCUP=1; BUSY high for exactly 4 cycles.
- RDPAR, zero-wait acks with data 0x10,0x20,0x30,0x40 → four PARWR pulses on consecutive cycles, PARIDX 0..3 with matching PARDAT, 4 CPINC, PARDN in the cycle of the fourth PARWR.
- RDCMD and RDPAR in the same cycle → command fetch only, no PARWR. Then RDPAR in the COMDN cycle → parameter fetch starts with RDREQ in the next cycle.
- SRESET asserted after the second parameter ack → IDLE next cycle, PARDN never pulses, CMDREG=0, and a fresh RDPAR restarts at PARIDX=0.
- Spurious RDACK in IDLE, and RDCMD during a parameter fetch → no CPINC, CMDREG unchanged, the parameter fetch completes normally.

Source files
------------

// File: rtl/blit_cmd_fetch_if.sv
// Blitter command fetch bus bundle.
// Groups the outer-loop request/done signals, the memory-read handshake and
// the parameter-register write port of blit_cmd_fetch.
//   slave  : the fetch responder (blit_cmd_fetch)
//   master : the surrounding outer loop / memory / parameter registers
interface blit_cmd_fetch_if;
   logic       RDCMD;
   logic       RDPAR;
   logic       RDACK;
   logic [7:0] RDDATA;
   logic       RDREQ;
   logic       CPINC;
   logic [7:0] CMDREG;
   logic       PARRD;
   logic       DSTUP;
   logic       SRCUP;
   logic       PARWR;
   logic [1:0] PARIDX;
   logic [7:0] PARDAT;
   logic       COMDN;
   logic       PARDN;
   logic       BUSY;

   modport slave (
      input  RDCMD, RDPAR, RDACK, RDDATA,
      output RDREQ, CPINC, CMDREG, PARRD, DSTUP, SRCUP,
             PARWR, PARIDX, PARDAT, COMDN, PARDN, BUSY
   );

   modport master (
      output RDCMD, RDPAR, RDACK, RDDATA,
      input  RDREQ, CPINC, CMDREG, PARRD, DSTUP, SRCUP,
             PARWR, PARIDX, PARDAT, COMDN, PARDN, BUSY
   );
endinterface

// File: rtl/blit_cmd_fetch.sv
// Blitter command/parameter fetch responder.
// Serves RDCMD (one command byte) and RDPAR (four parameter bytes) requests
// from the outer loop by reading bytes over the RDREQ/RDACK handshake.
// Ports:
//   CCLK   - clock, rising edge
//   SRESET - synchronous reset, active high
//   bus    - blit_cmd_fetch_if.slave: requests, memory read handshake,
//            command register/flags, parameter write strobe, done pulses
// All pulses and captured data appear the cycle after the acknowledge.
module blit_cmd_fetch (
   input logic               CCLK,
   input logic               SRESET,
   blit_cmd_fetch_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_PAR0 = 3'd2,
      S_PAR1 = 3'd3,
      S_PAR2 = 3'd4,
      S_PAR3 = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cmdreg_q, cmdreg_d;
   logic [7:0] pardat_q, pardat_d;
   logic [1:0] paridx_q, paridx_d;
   logic       cpinc_q, cpinc_d;
   logic       parwr_q, parwr_d;
   logic       comdn_q, comdn_d;
   logic       pardn_q, pardn_d;

   always_ff @(posedge CCLK) begin
      if (SRESET) begin
         state_q  <= S_IDLE;
         cmdreg_q <= 8'h00;
         pardat_q <= 8'h00;
         paridx_q <= 2'd0;
         cpinc_q  <= 1'b0;
         parwr_q  <= 1'b0;
         comdn_q  <= 1'b0;
         pardn_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmdreg_q <= cmdreg_d;
         pardat_q <= pardat_d;
         paridx_q <= paridx_d;
         cpinc_q  <= cpinc_d;
         parwr_q  <= parwr_d;
         comdn_q  <= comdn_d;
         pardn_q  <= pardn_d;
      end
   end

   // Parameter byte being fetched in the current PARk state.
   logic [1:0] par_k;

   always_comb begin
      state_d  = state_q;
      cmdreg_d = cmdreg_q;
      pardat_d = pardat_q;
      paridx_d = paridx_q;
      cpinc_d  = 1'b0;
      parwr_d  = 1'b0;
      comdn_d  = 1'b0;
      pardn_d  = 1'b0;
      par_k    = 2'd0;

      unique case (state_q)
         S_IDLE: begin
            // RDCMD wins a tie; a simultaneous RDPAR is dropped.
            if (bus.RDCMD)      state_d = S_CMD;
            else if (bus.RDPAR) state_d = S_PAR0;
         end
         S_CMD: begin
            if (bus.RDACK) begin
               cmdreg_d = bus.RDDATA;
               cpinc_d  = 1'b1;
               comdn_d  = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_PAR0, S_PAR1, S_PAR2, S_PAR3: begin
            unique case (state_q)
               S_PAR0:  par_k = 2'd0;
               S_PAR1:  par_k = 2'd1;
               S_PAR2:  par_k = 2'd2;
               default: par_k = 2'd3;
            endcase
            if (bus.RDACK) begin
               pardat_d = bus.RDDATA;
               paridx_d = par_k;
               parwr_d  = 1'b1;
               cpinc_d  = 1'b1;
               if (state_q == S_PAR3) begin
                  pardn_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = state_t'(state_q + 3'd1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request and busy are pure decodes of the registered state, so there is
   // no combinational path from RDACK to RDREQ.
   assign bus.RDREQ  = (state_q != S_IDLE);
   assign bus.BUSY   = (state_q != S_IDLE);
   assign bus.CPINC  = cpinc_q;
   assign bus.CMDREG = cmdreg_q;
   assign bus.PARRD  = cmdreg_q[7];
   assign bus.DSTUP  = cmdreg_q[6];
   assign bus.SRCUP  = cmdreg_q[5];
   assign bus.PARWR  = parwr_q;
   assign bus.PARIDX = paridx_q;
   assign bus.PARDAT = pardat_q;
   assign bus.COMDN  = comdn_q;
   assign bus.PARDN  = pardn_q;

endmodule

// File: tb/tb_blit_cmd_fetch.sv
// Self-checking bench for blit_cmd_fetch: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_blit_cmd_fetch;

   logic CCLK = 1'b0;
   logic SRESET = 1'b1;
   always #5 CCLK = ~CCLK;

   blit_cmd_fetch_if bus ();

   blit_cmd_fetch dut (
      .CCLK   (CCLK),
      .SRESET (SRESET),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Model: "a fetch is outstanding, of this kind, this many bytes in".
   bit       m_busy, m_is_par;
   int       m_bytes;
   bit [7:0] m_cmd, m_dat;
   bit [1:0] m_idx;
   bit       m_cpinc, m_parwr, m_comdn, m_pardn;

   // Observation counters for directed scenarios.
   int n_cpinc, n_parwr, n_comdn, n_pardn, n_busy, n_rdreq;
   bit [7:0] wr_dat[$];
   int       wr_idx[$];
   bit       pardn_with_last_wr;

   task automatic clr_cnt();
      n_cpinc = 0; n_parwr = 0; n_comdn = 0; n_pardn = 0; n_busy = 0; n_rdreq = 0;
      wr_dat.delete(); wr_idx.delete(); pardn_with_last_wr = 0;
   endtask

   task automatic model(input bit r, c, p, a, input bit [7:0] d);
      m_cpinc = 0; m_parwr = 0; m_comdn = 0; m_pardn = 0;
      if (r) begin
         m_busy = 0; m_cmd = 0; m_dat = 0; m_idx = 0;
      end else if (!m_busy) begin
         if (c)      begin m_busy = 1; m_is_par = 0; end
         else if (p) begin m_busy = 1; m_is_par = 1; m_bytes = 0; end
      end else if (a) begin
         m_cpinc = 1;
         if (!m_is_par) begin
            m_cmd = d; m_comdn = 1; m_busy = 0;
         end else begin
            m_dat = d; m_idx = 2'(m_bytes); m_parwr = 1;
            m_bytes++;
            if (m_bytes == 4) begin m_pardn = 1; m_busy = 0; end
         end
      end
   endtask

   function automatic logic [31:0] pack_dut();
      return {5'd0, bus.RDREQ, bus.BUSY, bus.CPINC, bus.PARWR, bus.COMDN, bus.PARDN,
              bus.PARRD, bus.DSTUP, bus.SRCUP, bus.PARIDX, bus.CMDREG, bus.PARDAT};
   endfunction

   function automatic logic [31:0] pack_model();
      return {5'd0, m_busy, m_busy, m_cpinc, m_parwr, m_comdn, m_pardn,
              m_cmd[7], m_cmd[6], m_cmd[5], m_idx, m_cmd, m_dat};
   endfunction

   task automatic step(input bit r, c, p, a, input bit [7:0] d);
      SRESET = r; bus.RDCMD = c; bus.RDPAR = p; bus.RDACK = a; bus.RDDATA = d;
      @(posedge CCLK);
      model(r, c, p, a, d);
      #1;
      chk("cycle_outputs", pack_dut(), pack_model());
      if (bus.CPINC) n_cpinc++;
      if (bus.PARWR) begin
         n_parwr++; wr_dat.push_back(bus.PARDAT); wr_idx.push_back(int'(bus.PARIDX));
         if (bus.PARDN && bus.PARIDX == 2'd3) pardn_with_last_wr = 1;
      end
      if (bus.COMDN) n_comdn++;
      if (bus.PARDN) n_pardn++;
      if (bus.BUSY)  n_busy++;
      if (bus.RDREQ) n_rdreq++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
   endtask

   initial begin
      bus.RDCMD = 0; bus.RDPAR = 0; bus.RDACK = 0; bus.RDDATA = 0;
      m_busy = 0; m_is_par = 0; m_bytes = 0; m_cmd = 0; m_dat = 0; m_idx = 0;
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);

      // Reset then idle.
      clr_cnt();
      idle(10);
      chk("idle_outputs", pack_dut(), 32'd0);
      chk("idle_rdreq_cnt", n_rdreq, 0);

      // Command fetch with 3 wait cycles.
      clr_cnt();
      step(0, 1, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 1, 8'hE0);
      chk("cmd_comdn", bus.COMDN, 1);
      idle(3);
      chk("cmd_cpinc_cnt", n_cpinc, 1);
      chk("cmd_comdn_cnt", n_comdn, 1);
      chk("cmd_busy_cycles", n_busy, 4);
      chk("cmd_cmdreg", bus.CMDREG, 8'hE0);
      chk("cmd_flags", {bus.PARRD, bus.DSTUP, bus.SRCUP}, 3'b111);

      // Zero-wait parameter fetch.
      clr_cnt();
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h10);
      step(0, 0, 0, 1, 8'h20);
      step(0, 0, 0, 1, 8'h30);
      step(0, 0, 0, 1, 8'h40);
      step(0, 0, 0, 0, 8'h00);
      chk("par_parwr_cnt", n_parwr, 4);
      chk("par_cpinc_cnt", n_cpinc, 4);
      chk("par_pardn_cnt", n_pardn, 1);
      chk("par_pardn_with_wr3", pardn_with_last_wr, 1);
      for (int i = 0; i < 4 && i < wr_dat.size(); i++) begin
         chk("par_idx", wr_idx[i], i);
         chk("par_dat", wr_dat[i], 8'(8'h10 * (i + 1)));
      end

      // RDCMD and RDPAR together, then RDPAR in the COMDN cycle.
      clr_cnt();
      step(0, 1, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h25);
      chk("tie_comdn", bus.COMDN, 1);
      step(0, 0, 1, 0, 8'h00);
      chk("b2b_rdreq", bus.RDREQ, 1);
      chk("tie_no_parwr", n_parwr, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'(8'hA0 + i));
      step(0, 0, 0, 0, 8'h00);
      chk("b2b_pardn_cnt", n_pardn, 1);
      chk("b2b_cmdreg", bus.CMDREG, 8'h25);

      // Reset after the second parameter ack (ack held during reset).
      clr_cnt();
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h11);
      step(0, 0, 0, 1, 8'h22);
      step(1, 0, 0, 1, 8'h33);
      chk("rst_outputs", pack_dut(), 32'd0);
      idle(6);
      chk("rst_no_pardn", n_pardn, 0);
      chk("rst_cmdreg", bus.CMDREG, 8'h00);
      step(0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 8'h5A);
      chk("rst_restart_idx", bus.PARIDX, 2'd0);
      chk("rst_restart_dat", bus.PARDAT, 8'h5A);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h01);

      // Command, spurious ack in IDLE, RDCMD during a parameter fetch.
      step(0, 1, 0, 1, 8'h00);
      step(0, 0, 0, 1, 8'h6B);
      idle(1);
      clr_cnt();
      step(0, 0, 0, 1, 8'hFF);
      step(0, 0, 0, 1, 8'hFE);
      chk("spur_cpinc", n_cpinc, 0);
      chk("spur_cmdreg", bus.CMDREG, 8'h6B);
      step(0, 0, 1, 0, 8'h00);
      step(0, 1, 0, 1, 8'h01);
      step(0, 1, 0, 1, 8'h02);
      step(0, 1, 0, 1, 8'h03);
      step(0, 0, 0, 1, 8'h04);
      step(0, 0, 0, 0, 8'h00);
      chk("midcmd_pardn", n_pardn, 1);
      chk("midcmd_comdn", n_comdn, 0);
      chk("midcmd_cpinc", n_cpinc, 4);
      chk("midcmd_cmdreg", bus.CMDREG, 8'h6B);

      // Random traffic.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, 8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
